// File: rtl/fp16_pkg.sv
// Shared definitions for the half-precision add/subtract controller:
// FSM encoding, field widths, special constants and the operand unpack helper.
package fp16_pkg;

    localparam int unsigned FP_W   = 16;
    localparam int unsigned EXP_W  = 5;
    localparam int unsigned FRAC_W = 10;
    localparam int unsigned MANT_W = 13;          // {hidden, frac, 2 guard bits}
    localparam int unsigned SUM_W  = MANT_W + 1;  // adds one carry bit
    localparam int unsigned BIAS   = 15;

    localparam logic [FP_W-1:0]  QNAN    = 16'h7E00;
    localparam logic [FP_W-1:0]  POS_INF = 16'h7C00;
    localparam logic [EXP_W-1:0] EXP_MAX = 5'h1F;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ALIGN = 3'd1,
        ST_ADD   = 3'd2,
        ST_NORM  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [FRAC_W-1:0] frac;
    } fp16_t;

    // Aligned operand pair handed from ALIGN to ADD.
    typedef struct packed {
        logic              nan;
        logic              eff_sub;
        logic              sign_big;
        logic              sign_sml;
        logic [EXP_W-1:0]  exp;
        logic [MANT_W-1:0] mant_big;
        logic [MANT_W-1:0] mant_sml;
    } align_t;

    // Exponent 0 is treated as zero, so subnormals flush here.
    function automatic logic [MANT_W-1:0] unpack_mant(input fp16_t x);
        return (x.exp == '0) ? '0 : {1'b1, x.frac, 2'b00};
    endfunction

endpackage

// File: rtl/compare_and_shift.sv
// Combinational alignment: picks the larger-exponent operand and right-shifts
// the other mantissa by the exponent difference.
// Ports:
//   i_a, i_b     half-precision operands
//   i_op         0 = A+B, 1 = A-B (inverts B's sign)
//   o_align_c    aligned mantissas, common exponent, signs, NaN flag
module compare_and_shift
    import fp16_pkg::*;
(
    input  logic [FP_W-1:0] i_a,
    input  logic [FP_W-1:0] i_b,
    input  logic            i_op,
    output align_t          o_align_c
);

    fp16_t             w_a;
    fp16_t             w_b;
    logic              w_b_sign;
    logic              w_a_big;
    logic [EXP_W-1:0]  w_diff;
    logic [MANT_W-1:0] w_mant_a;
    logic [MANT_W-1:0] w_mant_b;
    logic [MANT_W-1:0] w_mant_sml_raw;

    assign w_a = i_a;
    assign w_b = i_b;

    always_comb begin
        o_align_c      = '0;
        w_b_sign       = w_b.sign ^ i_op;
        w_a_big        = (w_a.exp >= w_b.exp);
        w_diff         = w_a_big ? (w_a.exp - w_b.exp) : (w_b.exp - w_a.exp);
        w_mant_a       = unpack_mant(w_a);
        w_mant_b       = unpack_mant(w_b);
        w_mant_sml_raw = w_a_big ? w_mant_b : w_mant_a;

        o_align_c.nan      = (w_a.exp == EXP_MAX) || (w_b.exp == EXP_MAX);
        o_align_c.eff_sub  = w_a.sign ^ w_b_sign;
        o_align_c.sign_big = w_a_big ? w_a.sign : w_b_sign;
        o_align_c.sign_sml = w_a_big ? w_b_sign : w_a.sign;
        o_align_c.exp      = w_a_big ? w_a.exp : w_b.exp;
        o_align_c.mant_big = w_a_big ? w_mant_a : w_mant_b;
        // A shift of 13 or more moves every bit out.
        o_align_c.mant_sml = (w_diff >= EXP_W'(MANT_W)) ? '0 : (w_mant_sml_raw >> w_diff);
    end

endmodule

// File: rtl/fp16_addsub_ctrl.sv
// Multi-cycle IEEE-754 half-precision adder/subtractor with valid/ready
// handshakes on both sides. Truncating rounding, subnormals flushed to zero.
// Ports:
//   clk, rst_n             clock, async active-low reset
//   in_valid / in_ready    operation handshake (ready only in IDLE)
//   a, b, op               operands, 0 = A+B, 1 = A-B
//   out_valid / out_ready  result handshake (result held until accepted)
//   result                 half-precision result
//   busy                   high in every state except IDLE
module fp16_addsub_ctrl
    import fp16_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [FP_W-1:0] a,
    input  logic [FP_W-1:0] b,
    input  logic            op,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [FP_W-1:0] result,
    output logic            busy
);

    state_t            r_state;
    state_t            w_state_nxt;

    logic [FP_W-1:0]   r_a;
    logic [FP_W-1:0]   r_b;
    logic              r_op;
    align_t            r_align;
    align_t            w_align_c;

    logic              r_sign;
    logic [EXP_W-1:0]  r_exp;
    logic [SUM_W-1:0]  r_mant;
    logic              r_nan;

    logic [FP_W-1:0]   r_result;
    logic              r_out_valid;
    logic              r_in_ready;
    logic              r_busy;

    logic              w_in_xfer;
    logic [SUM_W-1:0]  w_sum;
    logic              w_sum_sign;

    logic [SUM_W-1:0]  w_shl;
    logic [EXP_W-1:0]  w_exp_inc;
    logic [EXP_W-1:0]  w_exp_dec;
    logic              w_nm_done;
    logic [SUM_W-1:0]  w_nm_mant;
    logic [EXP_W-1:0]  w_nm_exp;
    logic [FP_W-1:0]   w_nm_result;

    assign w_in_xfer = in_valid && r_in_ready;

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign busy      = r_busy;

    // Alignment of the captured operands.
    compare_and_shift u_align (
        .i_a       (r_a),
        .i_b       (r_b),
        .i_op      (r_op),
        .o_align_c (w_align_c)
    );

    // Mantissa add / magnitude subtract on the aligned pair.
    always_comb begin
        w_sum      = '0;
        w_sum_sign = r_align.sign_big;
        if (!r_align.eff_sub) begin
            w_sum = {1'b0, r_align.mant_big} + {1'b0, r_align.mant_sml};
        end else if (r_align.mant_big >= r_align.mant_sml) begin
            w_sum = {1'b0, r_align.mant_big} - {1'b0, r_align.mant_sml};
        end else begin
            // Equal exponents with B larger: the smaller-exponent slot holds the bigger value.
            w_sum      = {1'b0, r_align.mant_sml} - {1'b0, r_align.mant_big};
            w_sum_sign = r_align.sign_sml;
        end
    end

    // One normalisation step; the packed result is ready when w_nm_done.
    always_comb begin
        w_shl       = {r_mant[SUM_W-2:0], 1'b0};
        w_exp_inc   = r_exp + EXP_W'(1);
        w_exp_dec   = r_exp - EXP_W'(1);
        w_nm_done   = 1'b0;
        w_nm_mant   = r_mant;
        w_nm_exp    = r_exp;
        w_nm_result = '0;
        if (r_nan) begin
            w_nm_done   = 1'b1;
            w_nm_result = QNAN;
        end else if (r_mant == '0) begin
            w_nm_done   = 1'b1;
            w_nm_result = '0;
        end else if (r_mant[SUM_W-1]) begin
            // Carry out: single right shift, frac comes from bits [12:3].
            w_nm_done = 1'b1;
            if (w_exp_inc == EXP_MAX) begin
                w_nm_result = {r_sign, POS_INF[FP_W-2:0]};
            end else begin
                w_nm_result = {r_sign, w_exp_inc, r_mant[MANT_W-1 -: FRAC_W]};
            end
        end else if (r_mant[MANT_W-1]) begin
            w_nm_done   = 1'b1;
            w_nm_result = {r_sign, r_exp, r_mant[MANT_W-2 -: FRAC_W]};
        end else if (w_exp_dec == '0) begin
            w_nm_done   = 1'b1;
            w_nm_result = {r_sign, {(FP_W-1){1'b0}}};
        end else begin
            w_nm_mant = w_shl;
            w_nm_exp  = w_exp_dec;
            if (w_shl[MANT_W-1]) begin
                w_nm_done   = 1'b1;
                w_nm_result = {r_sign, w_exp_dec, w_shl[MANT_W-2 -: FRAC_W]};
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_in_xfer) w_state_nxt = ST_ALIGN;
            ST_ALIGN: w_state_nxt = ST_ADD;
            ST_ADD:   w_state_nxt = ST_NORM;
            ST_NORM:  if (w_nm_done) w_state_nxt = ST_DONE;
            ST_DONE:  if (out_ready) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Datapath registers and registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a         <= '0;
            r_b         <= '0;
            r_op        <= 1'b0;
            r_align     <= '0;
            r_sign      <= 1'b0;
            r_exp       <= '0;
            r_mant      <= '0;
            r_nan       <= 1'b0;
            r_result    <= '0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_in_xfer) begin
                        r_a  <= a;
                        r_b  <= b;
                        r_op <= op;
                    end
                end
                ST_ALIGN: r_align <= w_align_c;
                ST_ADD: begin
                    r_mant <= w_sum;
                    r_sign <= w_sum_sign;
                    r_exp  <= r_align.exp;
                    r_nan  <= r_align.nan;
                end
                ST_NORM: begin
                    r_mant <= w_nm_mant;
                    r_exp  <= w_nm_exp;
                    if (w_nm_done) r_result <= w_nm_result;
                end
                default: ;
            endcase
            r_out_valid <= (w_state_nxt == ST_DONE);
            r_in_ready  <= (w_state_nxt == ST_IDLE);
            r_busy      <= (w_state_nxt != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_fp16_addsub_ctrl.sv
// Directed bench for fp16_addsub_ctrl with hand-computed expected results.
module tb_fp16_addsub_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] a = 16'h0000;
    logic [15:0] b = 16'h0000;
    logic        op = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] result;
    logic        busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fp16_addsub_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed 0x%04h expected 0x%04h", tag, obs, expv);
        end
    endtask

    // Issue one operation from IDLE, wait for the result, optionally check
    // latency (edges counted from the transfer edge inclusive) and hold it.
    task automatic run_op(input string tag, input logic [15:0] va, input logic [15:0] vb,
                          input logic vop, input logic [15:0] vres, input int lat, input int hold);
        int edges;
        a = va; b = vb; op = vop; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        edges = 1;
        while (out_valid !== 1'b1 && edges < 40) begin
            @(posedge clk); #1;
            edges++;
        end
        chk({tag, "_valid"}, 16'(out_valid), 16'h0001);
        chk({tag, "_result"}, result, vres);
        if (lat != 0) chk({tag, "_latency"}, 16'(edges), 16'(lat));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk({tag, "_hold_valid"}, 16'(out_valid), 16'h0001);
            chk({tag, "_hold_result"}, result, vres);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, "_released"}, 16'(out_valid), 16'h0000);
        chk({tag, "_idle"}, 16'(in_ready), 16'h0001);
    endtask

    initial begin
        int acc;
        int done;

        // Reset and reset values.
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_in_ready", 16'(in_ready), 16'h0001);
        chk("rst_out_valid", 16'(out_valid), 16'h0000);
        chk("rst_busy", 16'(busy), 16'h0000);
        chk("rst_result", result, 16'h0000);

        // Basic function, latency and boundary cases.
        run_op("add_1_2",      16'h3C00, 16'h4000, 1'b0, 16'h4200, 4,  3);
        run_op("sub_equal",    16'h3C00, 16'h3C00, 1'b1, 16'h0000, 4,  0);
        run_op("sub_11shift",  16'h3C00, 16'h3BFF, 1'b1, 16'h1000, 14, 0);
        run_op("overflow_inf", 16'h7BFF, 16'h7BFF, 1'b0, 16'h7C00, 4,  0);
        run_op("nan_a_inf",    16'h7C00, 16'h1234, 1'b0, 16'h7E00, 0,  0);
        run_op("nan_b_ninf",   16'h3C00, 16'hFC00, 1'b0, 16'h7E00, 0,  0);
        run_op("sub_neg",      16'h3C00, 16'h4000, 1'b1, 16'hBC00, 4,  0);
        run_op("mixed_add",    16'h3C00, 16'hC000, 1'b0, 16'hBC00, 0,  0);
        run_op("eq_exp_b_big", 16'h3C00, 16'h3E00, 1'b1, 16'hB800, 0,  0);
        run_op("neg_carry",    16'hBC00, 16'hBC00, 1'b0, 16'hC000, 0,  0);
        run_op("truncate",     16'h3C00, 16'h3C03, 1'b0, 16'h4001, 0,  0);
        run_op("align_diff2",  16'h4000, 16'h3800, 1'b0, 16'h4100, 0,  0);
        run_op("align_diff14", 16'h3C00, 16'h0400, 1'b0, 16'h3C00, 0,  0);
        run_op("zero_operand", 16'h0000, 16'h4200, 1'b0, 16'h4200, 0,  0);
        run_op("subnormal",    16'h0001, 16'h3C00, 1'b0, 16'h3C00, 0,  0);
        run_op("underflow",    16'h8800, 16'h87FF, 1'b1, 16'h8000, 5,  0);

        // Reset during NORM discards the operation.
        a = 16'h3C00; b = 16'h3BFF; op = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("norm_busy", 16'(busy), 16'h0001);
        chk("norm_no_valid", 16'(out_valid), 16'h0000);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", 16'(busy), 16'h0000);
        chk("midrst_out_valid", 16'(out_valid), 16'h0000);
        chk("midrst_in_ready", 16'(in_ready), 16'h0001);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        run_op("post_reset", 16'h4000, 16'hC000, 1'b0, 16'h0000, 4, 0);

        // Back-to-back requests: one op every 5 cycles, one result per op.
        acc = 0;
        done = 0;
        a = 16'h3C00; b = 16'h4000; op = 1'b0;
        in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 30; i++) begin
            chk("b2b_in_ready", 16'(in_ready), 16'((i % 5) == 0));
            chk("b2b_out_valid", 16'(out_valid), 16'((i % 5) == 4));
            if (in_ready === 1'b1) acc++;
            if (out_valid === 1'b1) begin
                done++;
                chk("b2b_result", result, 16'h4200);
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        @(posedge clk); #1;
        chk("b2b_accepted", 16'(acc), 16'd6);
        chk("b2b_results", 16'(done), 16'd6);
        chk("b2b_final_idle", 16'(busy), 16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
